// File: rtl/proc_pkg.sv
// Shared types and constants for the pipeline hazard/scoreboard unit.
//   hz_entry_t  : one tracked in-flight instruction {valid, rd, we, is_load}
//   FWD_REGFILE : bypass-select code meaning "read the register file"
// The rd field is sized for the widest supported register address.
// Narrower address spaces are zero-extended into it.
package proc_pkg;

  localparam int HZ_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               we;
    logic               is_load;
  } hz_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational source-operand matcher against the in-flight entry array.
// Ports:
//   src_i      : source register address
//   used_i     : the instruction in D actually reads this source
//   ent_i      : tracked entries, index 1 = X (youngest) .. N_STAGES = W
//   hit_o      : some writing entry targets src_i (x0 never matches)
//   idx_o      : stage index of the youngest matching entry (0 when no hit)
//   is_load_o  : the winning entry is a load
module hazard_match
  import proc_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int N_STAGES = 3,
  parameter int IDX_W    = $clog2(N_STAGES + 1)
) (
  input  logic [REG_AW-1:0]          src_i,
  input  logic                       used_i,
  input  hz_entry_t [N_STAGES:1]     ent_i,
  output logic                       hit_o,
  output logic [IDX_W-1:0]           idx_o,
  output logic                       is_load_o
);

  logic [HZ_RD_W-1:0] src_ext;

  assign src_ext = HZ_RD_W'(src_i);

  // Scan oldest to youngest so that a younger match overwrites an older one;
  // the youngest producer holds the most recent value of the register.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    if (used_i && (src_i != '0)) begin
      for (int k = N_STAGES; k >= 1; k--) begin
        if (ent_i[k].valid && ent_i[k].we && (ent_i[k].rd == src_ext)) begin
          hit_o     = 1'b1;
          idx_o     = IDX_W'(k);
          is_load_o = ent_i[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and scoreboard unit for the in-order integer pipeline.
// Tracks the destination of every instruction from X (stage 1) to W
// (stage N_STAGES), stalls decode on RAW hazards (or only on load-use when
// forwarding is enabled), squashes D on flush, freezes on ext_stall_i and
// counts hazard-stall cycles with saturation.
// Ports:
//   clk_i, rst_n_i           : clock, synchronous active-low reset
//   d_*_i                    : decode-slot instruction fields
//   flush_i                  : squash D (taken branch)
//   ext_stall_i              : freeze the whole pipe
//   stall_o                  : hold D and PC for a hazard
//   incr_pc_o                : PC may advance
//   fwd1_sel_o, fwd2_sel_o   : operand source, 0 = regfile, k = stage k
//   w_rd_o, w_we_o           : registered write-back address / enable
//   stall_cnt_o              : saturating hazard-stall cycle count
//
// Flow control: an instruction leaves D into X on a rising edge exactly when
// d_valid_i & ~stall_o & ~flush_i & ~ext_stall_i. While stall_o or
// ext_stall_i is high the front end must hold D and the PC unchanged
// (incr_pc_o low); a flushed D slot becomes a bubble in X.
module pipe_hazard_ctrl
  import proc_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int N_STAGES = 3,
  parameter int FWD_EN   = 0,
  parameter int CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        d_valid_i,
  input  logic [REG_AW-1:0]           d_rs1_i,
  input  logic                        d_rs1_used_i,
  input  logic [REG_AW-1:0]           d_rs2_i,
  input  logic                        d_rs2_used_i,
  input  logic [REG_AW-1:0]           d_rd_i,
  input  logic                        d_rd_we_i,
  input  logic                        d_is_load_i,
  input  logic                        flush_i,
  input  logic                        ext_stall_i,
  output logic                        stall_o,
  output logic                        incr_pc_o,
  output logic [$clog2(N_STAGES)-1:0] fwd1_sel_o,
  output logic [$clog2(N_STAGES)-1:0] fwd2_sel_o,
  output logic [REG_AW-1:0]           w_rd_o,
  output logic                        w_we_o,
  output logic [CNT_W-1:0]            stall_cnt_o
);

  localparam int SEL_W = $clog2(N_STAGES);
  localparam int IDX_W = $clog2(N_STAGES + 1);

  hz_entry_t [N_STAGES:1] ent_q, ent_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic             hit1, hit2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             ld1, ld2;
  logic             haz1, haz2, hazard;

  hazard_match #(
    .REG_AW   (REG_AW),
    .N_STAGES (N_STAGES),
    .IDX_W    (IDX_W)
  ) u_match_rs1 (
    .src_i     (d_rs1_i),
    .used_i    (d_rs1_used_i),
    .ent_i     (ent_q),
    .hit_o     (hit1),
    .idx_o     (idx1),
    .is_load_o (ld1)
  );

  hazard_match #(
    .REG_AW   (REG_AW),
    .N_STAGES (N_STAGES),
    .IDX_W    (IDX_W)
  ) u_match_rs2 (
    .src_i     (d_rs2_i),
    .used_i    (d_rs2_used_i),
    .ent_i     (ent_q),
    .hit_o     (hit2),
    .idx_o     (idx2),
    .is_load_o (ld2)
  );

  // A match in W is never a hazard: the regfile writes before it reads.
  // With forwarding only a load still in X cannot be bypassed.
  always_comb begin
    if (FWD_EN != 0) begin
      haz1 = hit1 && (idx1 == IDX_W'(1)) && ld1;
      haz2 = hit2 && (idx2 == IDX_W'(1)) && ld2;
    end else begin
      haz1 = hit1 && (idx1 != IDX_W'(N_STAGES));
      haz2 = hit2 && (idx2 != IDX_W'(N_STAGES));
    end
    hazard = haz1 || haz2;
  end

  always_comb begin
    fwd1_sel_o = SEL_W'(FWD_REGFILE);
    fwd2_sel_o = SEL_W'(FWD_REGFILE);
    if ((FWD_EN != 0) && !hazard) begin
      if (hit1 && (idx1 != IDX_W'(N_STAGES))) fwd1_sel_o = SEL_W'(idx1);
      if (hit2 && (idx2 != IDX_W'(N_STAGES))) fwd2_sel_o = SEL_W'(idx2);
    end
  end

  // Flush outranks a hazard: a squashed instruction has nothing to wait for.
  assign stall_o   = d_valid_i && !flush_i && hazard;
  assign incr_pc_o = !stall_o && !ext_stall_i;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (!ext_stall_i) begin
      for (int k = N_STAGES; k >= 2; k--) begin
        ent_d[k] = ent_q[k-1];
      end
      ent_d[1] = '0;
      if (d_valid_i && !stall_o && !flush_i) begin
        ent_d[1].valid   = 1'b1;
        ent_d[1].rd      = HZ_RD_W'(d_rd_i);
        ent_d[1].we      = d_rd_we_i;
        ent_d[1].is_load = d_is_load_i;
      end
      if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign w_rd_o      = ent_q[N_STAGES].rd[REG_AW-1:0];
  assign w_we_o      = ent_q[N_STAGES].valid && ent_q[N_STAGES].we;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one stall-only instance (CNT_W=4) and one
// forwarding instance, each driven by its own directed instruction stream.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
    logic       ext;
  } in_t;

  typedef struct packed {
    logic        dut;
    logic [7:0]  tag;
    logic [6:0]  care;
    logic        stall;
    logic        incr;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic        wwe;
    logic [4:0]  wrd;
    logic [15:0] cnt;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  localparam int X     = -1;
  localparam int D0    = 0;
  localparam int D1    = 1;

  logic             clk;
  logic             rst_n;
  in_t              in0, in1;
  logic [EXP_W-1:0] exp_q[$];
  int               checks;
  int               errors;

  logic       stall0, incr0, wwe0;
  logic [1:0] f1_0, f2_0;
  logic [4:0] wrd0;
  logic [3:0] cnt0;
  logic       stall1, incr1, wwe1;
  logic [1:0] f1_1, f2_1;
  logic [4:0] wrd1;
  logic [15:0] cnt1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  pipe_hazard_ctrl #(.REG_AW(5), .N_STAGES(3), .FWD_EN(0), .CNT_W(4)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .d_valid_i(in0.v), .d_rs1_i(in0.rs1), .d_rs1_used_i(in0.u1),
    .d_rs2_i(in0.rs2), .d_rs2_used_i(in0.u2), .d_rd_i(in0.rd),
    .d_rd_we_i(in0.we), .d_is_load_i(in0.ld), .flush_i(in0.fl),
    .ext_stall_i(in0.ext), .stall_o(stall0), .incr_pc_o(incr0),
    .fwd1_sel_o(f1_0), .fwd2_sel_o(f2_0), .w_rd_o(wrd0), .w_we_o(wwe0),
    .stall_cnt_o(cnt0)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .N_STAGES(3), .FWD_EN(1), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .d_valid_i(in1.v), .d_rs1_i(in1.rs1), .d_rs1_used_i(in1.u1),
    .d_rs2_i(in1.rs2), .d_rs2_used_i(in1.u2), .d_rd_i(in1.rd),
    .d_rd_we_i(in1.we), .d_is_load_i(in1.ld), .flush_i(in1.fl),
    .ext_stall_i(in1.ext), .stall_o(stall1), .incr_pc_o(incr1),
    .fwd1_sel_o(f1_1), .fwd2_sel_o(f2_1), .w_rd_o(wrd1), .w_we_o(wwe1),
    .stall_cnt_o(cnt1)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int dut, input int v, input int rs1, input int u1,
                     input int rs2, input int u2, input int rd, input int we,
                     input int ld, input int fl, input int ext);
    in_t t;
    t.v   = 1'(v);   t.rs1 = 5'(rs1); t.u1 = 1'(u1);
    t.rs2 = 5'(rs2); t.u2  = 1'(u2);  t.rd = 5'(rd);
    t.we  = 1'(we);  t.ld  = 1'(ld);  t.fl = 1'(fl);
    t.ext = 1'(ext);
    in0 = '0;
    in1 = '0;
    if (dut == 0) in0 = t;
    else          in1 = t;
  endtask

  task automatic idle();
    drv(D0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Push expected outputs for the current row; X marks a field not checked.
  task automatic exp_push(input int tag, input int dut, input int stall,
                          input int incr, input int f1, input int f2,
                          input int wwe, input int wrd, input int cnt);
    exp_t e;
    e       = '0;
    e.dut   = 1'(dut);
    e.tag   = 8'(tag);
    e.care  = {stall != X, incr != X, f1 != X, f2 != X, wwe != X, wrd != X, cnt != X};
    e.stall = 1'(stall);
    e.incr  = 1'(incr);
    e.f1    = 2'(f1);
    e.f2    = 2'(f2);
    e.wwe   = 1'(wwe);
    e.wrd   = 5'(wrd);
    e.cnt   = 16'(cnt);
    exp_q.push_back(e);
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string nm, input int dut, input int tag,
                     input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s dut%0d row %0d: got %0d want %0d", nm, dut, tag, act, want);
    end
  endtask

  exp_t mon_e;
  exp_t mon_a;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '0;
      if (mon_e.dut == 1'b0) begin
        mon_a.stall = stall0; mon_a.incr = incr0; mon_a.f1 = f1_0;
        mon_a.f2 = f2_0; mon_a.wwe = wwe0; mon_a.wrd = wrd0;
        mon_a.cnt = 16'(cnt0);
      end else begin
        mon_a.stall = stall1; mon_a.incr = incr1; mon_a.f1 = f1_1;
        mon_a.f2 = f2_1; mon_a.wwe = wwe1; mon_a.wrd = wrd1;
        mon_a.cnt = cnt1;
      end
      if (mon_e.care[6]) chk("stall", mon_e.dut, mon_e.tag, mon_a.stall, mon_e.stall);
      if (mon_e.care[5]) chk("incr_pc", mon_e.dut, mon_e.tag, mon_a.incr, mon_e.incr);
      if (mon_e.care[4]) chk("fwd1_sel", mon_e.dut, mon_e.tag, mon_a.f1, mon_e.f1);
      if (mon_e.care[3]) chk("fwd2_sel", mon_e.dut, mon_e.tag, mon_a.f2, mon_e.f2);
      if (mon_e.care[2]) chk("w_we", mon_e.dut, mon_e.tag, mon_a.wwe, mon_e.wwe);
      if (mon_e.care[1]) chk("w_rd", mon_e.dut, mon_e.tag, mon_a.wrd, mon_e.wrd);
      if (mon_e.care[0]) chk("stall_cnt", mon_e.dut, mon_e.tag, mon_a.cnt, mon_e.cnt);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cur;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // reset state, both instances
    idle();
    exp_push(0, D0, 0, 1, 0, 0, 0, 0, 0);
    exp_push(0, D1, 0, 1, 0, 0, 0, 0, 0);
    tick();

    // ---- stall-only distance: add x5, then consumer of x5 ----
    drv(D0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); exp_push(1, D0, 0, 1, 0, 0, X, X, 0); tick();
    drv(D0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0); exp_push(2, D0, 1, 0, 0, 0, X, X, 0); tick();
    drv(D0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0); exp_push(3, D0, 1, 0, 0, 0, X, X, 1); tick();
    drv(D0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0); exp_push(4, D0, 0, 1, 0, 0, 1, 5, 2); tick();
    idle();                                exp_push(5, D0, 0, 1, 0, 0, 0, X, 2); tick();
    idle(); tick();
    idle(); tick();

    // ---- x0 / non-writing producer / unused source ----
    drv(D0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); exp_push(6, D0, 0, 1, 0, 0, X, X, 2); tick();
    drv(D0, 1, 0, 1, 0, 0, 3, 0, 0, 0, 0); exp_push(7, D0, 0, 1, 0, 0, X, X, 2); tick();
    drv(D0, 1, 3, 1, 0, 1, 9, 1, 0, 0, 0); exp_push(8, D0, 0, 1, 0, 0, X, X, 2); tick();
    drv(D0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0); exp_push(9, D0, 0, 1, 0, 0, X, X, 2); tick();
    idle(); tick();
    idle(); tick();
    idle(); tick();

    // ---- freeze: X=x12, M=x11, W=x10 held for 3 cycles ----
    drv(D0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0); exp_push(10, D0, 0, 1, 0, 0, 0, X, 2); tick();
    drv(D0, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0); tick();
    drv(D0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0); tick();
    drv(D0, 1, 12, 1, 0, 0, 13, 1, 0, 0, 1); exp_push(11, D0, 1, 0, 0, 0, 1, 10, 2); tick();
    drv(D0, 1, 12, 1, 0, 0, 13, 1, 0, 0, 1); exp_push(12, D0, 1, 0, 0, 0, 1, 10, 2); tick();
    drv(D0, 1, 12, 1, 0, 0, 13, 1, 0, 1, 1); exp_push(13, D0, 0, 0, 0, 0, 1, 10, 2); tick();
    idle(); exp_push(14, D0, 0, 1, 0, 0, 1, 10, 2); tick();
    idle(); exp_push(15, D0, 0, 1, 0, 0, 1, 11, 2); tick();
    idle(); exp_push(16, D0, 0, 1, 0, 0, 1, 12, 2); tick();

    // ---- flush over a hazard leaves a bubble in X ----
    drv(D0, 1, 0, 0, 0, 0, 20, 1, 0, 0, 0);  exp_push(17, D0, 0, 1, 0, 0, 0, X, 2); tick();
    drv(D0, 1, 20, 1, 0, 0, 21, 1, 0, 1, 0); exp_push(18, D0, 0, 1, 0, 0, X, X, 2); tick();
    drv(D0, 1, 0, 0, 21, 1, 0, 0, 0, 0, 0);  exp_push(19, D0, 0, 1, 0, 0, X, X, 2); tick();
    idle(); exp_push(20, D0, 0, 1, 0, 0, 1, 20, 2); tick();
    idle(); exp_push(21, D0, 0, 1, 0, 0, 0, X, 2); tick();

    // ---- 20 more stall cycles: 4-bit counter saturates at 15 ----
    cur = 2;
    for (int i = 0; i < 10; i++) begin
      drv(D0, 1, 0, 0, 0, 0, 26, 1, 0, 0, 0);
      exp_push(100 + i, D0, 0, 1, 0, 0, X, X, cur); tick();
      drv(D0, 1, 26, 1, 0, 0, 0, 0, 0, 0, 0);
      exp_push(100 + i, D0, 1, 0, 0, 0, X, X, cur); tick();
      exp_push(100 + i, D0, 1, 0, 0, 0, X, X, sat15(cur + 1)); tick();
      exp_push(100 + i, D0, 0, 1, 0, 0, 1, 26, sat15(cur + 2)); tick();
      cur = sat15(cur + 2);
    end
    idle(); exp_push(22, D0, 0, 1, 0, 0, X, X, 15); tick();

    // ---- reset mid-stream: x27 in W, x28 entering X ----
    drv(D0, 1, 0, 0, 0, 0, 27, 1, 0, 0, 0); tick();
    idle(); tick();
    idle(); tick();
    rst_n = 1'b0;
    drv(D0, 1, 0, 0, 0, 0, 28, 1, 0, 0, 0); exp_push(23, D0, 0, 1, 0, 0, 1, 27, 15); tick();
    rst_n = 1'b1;
    idle();
    exp_push(24, D0, 0, 1, 0, 0, 0, 0, 0);
    exp_push(24, D1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    idle(); exp_push(25, D0, 0, 1, 0, 0, 0, X, 0); tick();
    idle(); exp_push(26, D0, 0, 1, 0, 0, 0, X, 0); tick();

    // ---- forwarding distance ----
    drv(D1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); exp_push(50, D1, 0, 1, 0, 0, X, X, 0); tick();
    drv(D1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0); exp_push(51, D1, 0, 1, 1, 0, X, X, 0); tick();
    drv(D1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); exp_push(52, D1, 0, 1, 2, 0, X, X, 0); tick();
    drv(D1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); exp_push(53, D1, 0, 1, 0, 0, 1, 5, 0); tick();
    // youngest of two producers of x8 wins
    drv(D1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0); exp_push(54, D1, 0, 1, 0, 0, X, X, 0); tick();
    drv(D1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0); exp_push(55, D1, 0, 1, 0, 0, X, X, 0); tick();
    drv(D1, 1, 8, 1, 8, 1, 9, 1, 0, 0, 0); exp_push(56, D1, 0, 1, 1, 1, X, X, 0); tick();

    // ---- load-use on rs2; rs1 bypass suppressed during the stall ----
    drv(D1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0); exp_push(57, D1, 0, 1, 0, 0, 1, 8, 0); tick();
    drv(D1, 1, 9, 1, 7, 1, 0, 0, 0, 0, 0); exp_push(58, D1, 1, 0, 0, 0, 1, 8, 0); tick();
    drv(D1, 1, 9, 1, 7, 1, 0, 0, 0, 0, 0); exp_push(59, D1, 0, 1, 0, 2, 1, 9, 1); tick();
    drv(D1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_push(60, D1, 0, 1, 0, 0, 1, 7, 1); tick();

    // ---- x0 / non-writing producer / unused source with forwarding ----
    drv(D1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); exp_push(61, D1, 0, 1, 0, 0, X, X, 1); tick();
    drv(D1, 1, 0, 1, 0, 0, 3, 0, 0, 0, 0); exp_push(62, D1, 0, 1, 0, 0, X, X, 1); tick();
    drv(D1, 1, 3, 1, 0, 1, 9, 1, 0, 0, 0); exp_push(63, D1, 0, 1, 0, 0, X, X, 1); tick();
    drv(D1, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0); exp_push(64, D1, 0, 1, 0, 0, X, X, 1); tick();
    drv(D1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // every pushed expectation must have been consumed
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and scoreboard unit for the in-order RISC-V integer pipeline. It tracks the destination register of every in-flight instruction from X through W. On a RAW hazard it either stalls decode or, when forwarding is enabled, generates per-operand bypass selects and stalls only on load-use. It also handles branch flush of the decode slot, a whole-pipe external freeze, and a saturating stall-cycle counter.

Parameters:
REG_AW, 5, register address width; address 0 is hardwired zero and never a hazard.
N_STAGES, 3, tracked stages after D: stage 1 = X, stage N_STAGES = W. Legal values are 2..8.
FWD_EN, 0, 0 = stall-only mode, 1 = forwarding mode with load-use stall.
CNT_W, 16, width of the stall counter.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset; one clock, synchronous, active-low
d_valid_i  in  1  D holds a real instruction
d_rs1_i  in  REG_AW  source 1 address
d_rs1_used_i  in  1  D reads rs1
d_rs2_i  in  REG_AW  source 2 address
d_rs2_used_i  in  1  D reads rs2
d_rd_i  in  REG_AW  destination address
d_rd_we_i  in  1  D writes rd
d_is_load_i  in  1  D is a load; result is available only from stage 2
flush_i  in  1  squash the D instruction (taken branch resolved in X)
ext_stall_i  in  1  freeze the whole pipe (memory not ready)
stall_o  out  1  hold D and PC because of a hazard
incr_pc_o  out  1  PC may advance
fwd1_sel_o  out  $clog2(N_STAGES)  rs1 source: 0 = regfile, k = stage k result
fwd2_sel_o  out  $clog2(N_STAGES)  rs2 source, same encoding
w_rd_o  out  REG_AW  write-back address
w_we_o  out  1  write-back enable
stall_cnt_o  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Stage register entry k = {valid, rd, we, is_load}, for k = 1..N_STAGES. Reset clears every entry, so every output resets to 0 except incr_pc_o, which resets to 1.
- Advance: if ext_stall_i = 0, entry k+1 <= entry k for every k. Entry 1 <= D fields when d_valid_i & ~stall_o & ~flush_i; otherwise entry 1 becomes a bubble (valid = 0).
- Freeze: if ext_stall_i = 1, every entry holds its value. flush_i is ignored that cycle; the flush source must hold flush_i until ext_stall_i falls.
- Match, per source s: s is used, s != 0, and some entry k has valid & we & rd == s. If several entries match, the smallest k (youngest) wins. A match at k = N_STAGES is not a hazard: the regfile writes before it reads in the same cycle.
- FWD_EN = 0:
  - hazard = any match with k <= N_STAGES-1.
  - fwd selects are forced to 0.
- FWD_EN = 1:
  - hazard = the winning match is k = 1 with is_load set (load-use).
  - Otherwise fwd_sel = winning k when k <= N_STAGES-1, else 0.
  - While hazard = 1, both fwd selects are 0.
- stall_o = d_valid_i & ~flush_i & hazard. flush_i has priority over a hazard.
- incr_pc_o = ~stall_o & ~ext_stall_i. This output is combinational.
- w_rd_o = entry N rd and w_we_o = entry N valid & we. Both are registered, so they carry no combinational path from the inputs.
- stall_cnt_o increments by 1 on each cycle with stall_o & ~ext_stall_i. It saturates at 2^CNT_W-1 and clears only on reset.
- Reset asserted mid-operation: all entries and the counter clear at the next edge. No in-flight write-back survives.

Decomposition:
- proc_pkg gains typedef hz_entry_t {valid, rd, we, is_load}.
- proc_pkg gains constant FWD_REGFILE = 0.
- Sub-module hazard_match (combinational) is instantiated once per source operand. Inputs: the source address, the used flag, and the entry array. Outputs: hit, winning index and is_load of the winner.

Test Plan:
- Stall-only distance: FWD_EN=0. Issue add writing x5, then the next instruction reads rs1=x5. Required: stall_o=1 for exactly 2 cycles, incr_pc_o=0 for those 2 cycles, then stall_o=0 once x5 reaches W. stall_cnt_o=2.
- Forwarding distance: FWD_EN=1, same sequence. Required: stall_o=0 and fwd1_sel_o=1. With the consumer one instruction later, fwd1_sel_o=2. With it two instructions later, fwd1_sel_o=0.
- Load-use: FWD_EN=1. Load writing x7, then rs2=x7. Required: stall_o=1 for 1 cycle with fwd2_sel_o=0, then fwd2_sel_o=2 on the next cycle.
- x0 and unused sources: rd=x0 with we=1 then rs1=x0; also rd=x3 with we=0 then rs1=x3; also d_rs2_used_i=0 with d_rs2_i matching. Required: no stall and fwd selects 0 in all three cases.
- Freeze: ext_stall_i held for 3 cycles. Required: entries unchanged, w_rd_o/w_we_o constant, incr_pc_o=0, stall_cnt_o not incrementing. Also flush_i asserted during the freeze is ignored.
- Flush, saturation and reset: flush_i while a hazard is present gives stall_o=0 and a bubble in X. With CNT_W=4 and 20 stall cycles, stall_cnt_o holds at 15. rst_n_i=0 for 1 cycle mid-stream gives w_we_o=0, all entries clear and stall_cnt_o=0 on the next edge.
